// File: rtl/minmax_frame.sv
// minmax_frame
// Streaming min/max tracker. Samples arrive on a valid/ready stream and are
// grouped into frames of up to FRAME_LEN samples (a frame closes early when
// in_last is set on an accepted sample). For every frame the block reports the
// smallest and largest sample, the 0-based in-frame index of each, and the
// number of samples, through a valid/ready result port.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   in_valid     sample present
//   in_ready     block can accept a sample
//   in_data      sample value (W bits)
//   in_last      accepted sample is the last of its frame
//   out_valid    frame result present
//   out_ready    downstream accepts result
//   out_min      smallest sample in frame
//   out_max      largest sample in frame
//   out_min_idx  index of out_min (earliest on ties)
//   out_max_idx  index of out_max (earliest on ties)
//   out_count    samples in frame, 1..FRAME_LEN
module minmax_frame #(
  parameter int W         = 8,
  parameter int FRAME_LEN = 16,
  parameter bit SIGNED    = 1'b0,
  localparam int IDXW     = $clog2(FRAME_LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_min,
  output logic [W-1:0]    out_max,
  output logic [IDXW-1:0] out_min_idx,
  output logic [IDXW-1:0] out_max_idx,
  output logic [IDXW:0]   out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_next;

  // Running accumulators for the frame in progress.
  logic [W-1:0]    acc_min, acc_max;
  logic [IDXW-1:0] acc_min_idx, acc_max_idx;
  logic [IDXW:0]   acc_count;

  // Values the accumulators take if the current sample is accepted.
  logic [W-1:0]    nxt_min, nxt_max;
  logic [IDXW-1:0] nxt_min_idx, nxt_max_idx;
  logic [IDXW:0]   nxt_count;

  logic accept, frame_end, transfer;
  logic lt_min, gt_max;

  assign accept    = in_valid & in_ready;
  assign transfer  = out_valid & out_ready;
  assign frame_end = accept & (in_last | (nxt_count == (IDXW+1)'(FRAME_LEN)));

  // Strict comparisons so an equal sample never displaces the earlier index.
  always_comb begin
    lt_min = 1'b0;
    gt_max = 1'b0;
    if (SIGNED) begin
      lt_min = $signed(in_data) < $signed(acc_min);
      gt_max = $signed(in_data) > $signed(acc_max);
    end else begin
      lt_min = in_data < acc_min;
      gt_max = in_data > acc_max;
    end
  end

  // The first sample of a frame seeds both extremes; later samples are folded
  // in with min and max updated independently. The in-frame index of a sample
  // in ACCUM equals the number of samples already taken.
  always_comb begin
    nxt_min     = acc_min;
    nxt_max     = acc_max;
    nxt_min_idx = acc_min_idx;
    nxt_max_idx = acc_max_idx;
    nxt_count   = acc_count + (IDXW+1)'(1);
    if (state == IDLE) begin
      nxt_min     = in_data;
      nxt_max     = in_data;
      nxt_min_idx = '0;
      nxt_max_idx = '0;
      nxt_count   = (IDXW+1)'(1);
    end else begin
      if (lt_min) begin
        nxt_min     = in_data;
        nxt_min_idx = acc_count[IDXW-1:0];
      end
      if (gt_max) begin
        nxt_max     = in_data;
        nxt_max_idx = acc_count[IDXW-1:0];
      end
    end
  end

  // Next-state and handshake outputs. in_ready also drops while reset is
  // asserted so nothing is taken during the reset cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = rst_n;
        if (accept) state_next = frame_end ? HOLD : ACCUM;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (transfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Accumulators advance on every accept; the result registers capture the
  // final folded values on the accept that closes the frame, so they already
  // include the last sample when HOLD is entered and stay put until the next
  // frame closes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_min     <= '0;
      acc_max     <= '0;
      acc_min_idx <= '0;
      acc_max_idx <= '0;
      acc_count   <= '0;
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
      out_count   <= '0;
    end else begin
      if (accept) begin
        acc_min     <= nxt_min;
        acc_max     <= nxt_max;
        acc_min_idx <= nxt_min_idx;
        acc_max_idx <= nxt_max_idx;
        acc_count   <= nxt_count;
      end
      if (frame_end) begin
        out_min     <= nxt_min;
        out_max     <= nxt_max;
        out_min_idx <= nxt_min_idx;
        out_max_idx <= nxt_max_idx;
        out_count   <= nxt_count;
      end
    end
  end

endmodule

// File: tb/tb_minmax_frame.sv
// tb_minmax_frame
// Drives two minmax_frame instances (FRAME_LEN=4, W=8), one unsigned and one
// signed, from a shared sample stream. A reference model turns each completed
// frame into expected results that are queued and compared when each instance
// hands its result over.
module tb_minmax_frame;

  localparam int FL = 4;

  typedef struct {
    logic [7:0] mn;
    logic [7:0] mx;
    logic [1:0] mni;
    logic [1:0] mxi;
    logic [2:0] cnt;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       soak = 1'b0;

  logic       in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [7:0] out_min_u, out_max_u, out_min_s, out_max_s;
  logic [1:0] out_min_idx_u, out_max_idx_u, out_min_idx_s, out_max_idx_s;
  logic [2:0] out_count_u, out_count_s;

  int total = 0;
  int bad   = 0;

  logic [7:0] fb[$];
  result_t    q_u[$];
  result_t    q_s[$];

  always #5 clk = ~clk;

  minmax_frame #(.W(8), .FRAME_LEN(FL), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_min(out_min_u), .out_max(out_max_u),
    .out_min_idx(out_min_idx_u), .out_max_idx(out_max_idx_u), .out_count(out_count_u)
  );

  minmax_frame #(.W(8), .FRAME_LEN(FL), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_min(out_min_s), .out_max(out_max_s),
    .out_min_idx(out_min_idx_s), .out_max_idx(out_max_idx_s), .out_count(out_count_s)
  );

  // Counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: scan the frame, keeping the first occurrence of each extreme.
  function automatic result_t frameModel(input logic [7:0] s[$], input bit sgn);
    result_t r;
    bit lt, gt;
    r.mn  = s[0];
    r.mx  = s[0];
    r.mni = '0;
    r.mxi = '0;
    r.cnt = 3'(s.size());
    for (int i = 1; i < s.size(); i++) begin
      if (sgn) begin
        lt = $signed(s[i]) < $signed(r.mn);
        gt = $signed(s[i]) > $signed(r.mx);
      end else begin
        lt = s[i] < r.mn;
        gt = s[i] > r.mx;
      end
      if (lt) begin r.mn = s[i]; r.mni = 2'(i); end
      if (gt) begin r.mx = s[i]; r.mxi = 2'(i); end
    end
    return r;
  endfunction

  // Offers one sample and holds it until accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready_u && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_u) checkOutput("accept_timeout", in_ready_u, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor at the falling edge: score result transfers, then record accepts
  // into the model frame buffer and queue expected results at frame end.
  always @(negedge clk) begin
    result_t e;
    if (!rst_n) begin
      fb.delete();
      q_u.delete();
      q_s.delete();
    end else begin
      if (out_valid_u && out_ready) begin
        checkOutput("u_expected_pending", 32'(q_u.size() != 0), 1);
        if (q_u.size() != 0) begin
          e = q_u.pop_front();
          checkOutput("u_min", out_min_u, e.mn);
          checkOutput("u_max", out_max_u, e.mx);
          checkOutput("u_min_idx", out_min_idx_u, e.mni);
          checkOutput("u_max_idx", out_max_idx_u, e.mxi);
          checkOutput("u_count", out_count_u, e.cnt);
        end
      end
      if (out_valid_s && out_ready) begin
        checkOutput("s_expected_pending", 32'(q_s.size() != 0), 1);
        if (q_s.size() != 0) begin
          e = q_s.pop_front();
          checkOutput("s_min", out_min_s, e.mn);
          checkOutput("s_max", out_max_s, e.mx);
          checkOutput("s_min_idx", out_min_idx_s, e.mni);
          checkOutput("s_max_idx", out_max_idx_s, e.mxi);
          checkOutput("s_count", out_count_s, e.cnt);
        end
      end
      if (in_valid && in_ready_u) begin
        fb.push_back(in_data);
        if (in_last || fb.size() == FL) begin
          q_u.push_back(frameModel(fb, 1'b0));
          q_s.push_back(frameModel(fb, 1'b1));
          fb.delete();
        end
      end
    end
  end

  // Random downstream backpressure during the soak.
  always @(posedge clk) begin
    if (soak) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [7:0] t2[4];
    int len, waited;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready_u, 0);
    checkOutput("rst_out_valid", out_valid_u, 0);
    checkOutput("rst_out_min", out_min_u, 0);
    checkOutput("rst_out_count", out_count_u, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("idle_in_ready", in_ready_u, 1);

    // 5,3,9,3 back-to-back: result one cycle after last accept, one bubble
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd3, 1'b0);
    applyStimulus(8'd9, 1'b0);
    applyStimulus(8'd3, 1'b0);
    checkOutput("t1_out_valid", out_valid_u, 1);
    checkOutput("t1_in_ready_hold", in_ready_u, 0);
    checkOutput("t1_min", out_min_u, 3);
    checkOutput("t1_min_idx", out_min_idx_u, 1);
    checkOutput("t1_max", out_max_u, 9);
    checkOutput("t1_max_idx", out_max_idx_u, 2);
    checkOutput("t1_count", out_count_u, 4);
    @(posedge clk);
    #1;
    checkOutput("t1_in_ready_after", in_ready_u, 1);
    checkOutput("t1_out_valid_after", out_valid_u, 0);

    // Signed versus unsigned ordering
    t2 = '{8'h7F, 8'h80, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) applyStimulus(t2[i], 1'b0);
    checkOutput("t2_s_min", out_min_s, 8'h80);
    checkOutput("t2_s_min_idx", out_min_idx_s, 1);
    checkOutput("t2_s_max", out_max_s, 8'h7F);
    checkOutput("t2_s_max_idx", out_max_idx_s, 0);
    checkOutput("t2_u_min", out_min_u, 8'h00);
    checkOutput("t2_u_min_idx", out_min_idx_u, 2);
    checkOutput("t2_u_max", out_max_u, 8'hFF);
    checkOutput("t2_u_max_idx", out_max_idx_u, 3);

    // Early frame end via in_last; single-sample frame
    applyStimulus(8'd10, 1'b0);
    applyStimulus(8'd20, 1'b1);
    checkOutput("t3_count2", out_count_u, 2);
    checkOutput("t3_max_idx", out_max_idx_u, 1);
    applyStimulus(8'd42, 1'b1);
    checkOutput("t3_single_valid", out_valid_u, 1);
    checkOutput("t3_single_min", out_min_u, 42);
    checkOutput("t3_single_max", out_max_u, 42);
    checkOutput("t3_single_count", out_count_u, 1);

    // All-equal frame keeps earliest indices
    for (int i = 0; i < 4; i++) applyStimulus(8'h55, 1'b0);
    checkOutput("t4_min_idx", out_min_idx_u, 0);
    checkOutput("t4_max_idx", out_max_idx_u, 0);

    // Backpressure: result held 6 cycles with a sample waiting
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(8'd8, 1'b0);
    applyStimulus(8'd1, 1'b0);
    applyStimulus(8'd6, 1'b0);
    applyStimulus(8'd2, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd7;
    in_last  = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("bp_in_ready", in_ready_u, 0);
      checkOutput("bp_out_valid", out_valid_u, 1);
      checkOutput("bp_min", out_min_u, 1);
      checkOutput("bp_max", out_max_u, 8);
      checkOutput("bp_max_idx", out_max_idx_u, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_no_accept_on_transfer", in_ready_u, 0);
    @(posedge clk);
    #1;
    checkOutput("bp_in_ready_after", in_ready_u, 1);
    checkOutput("bp_out_valid_after", out_valid_u, 0);
    applyStimulus(8'd7, 1'b1);

    // Reset mid-frame discards partial frame and zeroes outputs
    applyStimulus(8'd200, 1'b0);
    applyStimulus(8'd100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_out_valid", out_valid_u, 0);
    checkOutput("mid_rst_min", out_min_u, 0);
    checkOutput("mid_rst_max", out_max_u, 0);
    checkOutput("mid_rst_count", out_count_u, 0);
    checkOutput("mid_rst_in_ready", in_ready_u, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("post_rst_min", out_min_u, 1);
    checkOutput("post_rst_max", out_max_u, 4);
    checkOutput("post_rst_max_idx", out_max_idx_u, 3);
    checkOutput("post_rst_count", out_count_u, 4);

    // Random soak against the reference model
    soak = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        applyStimulus(8'($urandom_range(0, 255)), (i == len - 1));
      end
    end
    soak = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waited = 0;
    while ((q_u.size() != 0 || q_s.size() != 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    checkOutput("drain_u", q_u.size(), 0);
    checkOutput("drain_s", q_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
